// File: rtl/fetch_pc_unit.sv
// Fetch-stage next-PC generator with a prediction queue checked at EXEC.
// Optional FETCH_PC_STATS_EN adds saturating branch/mispredict counters.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned INSTR_BYTES = 4,
  parameter int unsigned PQ_DEPTH    = 4,
  localparam int unsigned PW = $clog2(PQ_DEPTH),
  localparam int unsigned CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic [31:0]   f_predict_addr,
  input  logic          f_predict_valid,
  input  logic          x_valid,
  input  logic          x_is_branch,
  input  logic          x_taken,
  input  logic [31:0]   x_target,
  output logic [31:0]   f_pc,
  output logic          f_pc_valid,
  output logic          x_mispredict,
  output logic [31:0]   x_redirect_pc,
  output logic [CW-1:0] pq_count,
  output logic          x_err
`ifdef FETCH_PC_STATS_EN
  ,
  output logic [31:0]   stat_branches,
  output logic [31:0]   stat_mispredicts
`endif
);

  localparam logic [CW-1:0] FULL_CNT = CW'(PQ_DEPTH);
  localparam logic [31:0]   STEP     = 32'(INSTR_BYTES);

  logic [31:0]         f_pc_q, f_pc_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [PW-1:0]       wr_q, wr_d;
  logic [PW-1:0]       rd_q, rd_d;
  logic                err_q, err_d;
  logic [PQ_DEPTH-1:0] tk_q, tk_d;
  logic [31:0]         tgt_q [PQ_DEPTH];
  logic [31:0]         tgt_d [PQ_DEPTH];
  logic [31:0]         ft_q  [PQ_DEPTH];
  logic [31:0]         ft_d  [PQ_DEPTH];

  logic        pq_empty;
  logic        pop;
  logic        fire;
  logic        pc_valid;
  logic        mispredict;
  logic        br_miss;
  logic        h_taken;
  logic [31:0] h_target;
  logic [31:0] h_ft;
  logic [31:0] redirect;
  logic [31:0] seq_pc;

  always_comb begin
    pq_empty = (cnt_q == '0);
    pop      = x_valid & ~pq_empty;
    h_taken  = tk_q[rd_q];
    h_target = tgt_q[rd_q];
    h_ft     = ft_q[rd_q];
    br_miss  = (x_taken != h_taken)
             | (x_taken & (x_target != h_target));
    // a non-branch that was predicted taken is an aliased prediction
    mispredict = pop & (x_is_branch ? br_miss : h_taken);
    redirect   = (x_is_branch & x_taken) ? x_target : h_ft;
    pc_valid   = (cnt_q != FULL_CNT) | pop;
    fire       = pc_valid & ~stall & ~mispredict;
    seq_pc     = f_pc_q + STEP;
  end

  always_comb begin
    f_pc_d = f_pc_q;
    cnt_d  = cnt_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    tk_d   = tk_q;
    tgt_d  = tgt_q;
    ft_d   = ft_q;
    err_d  = err_q | (x_valid & pq_empty);

    if (mispredict) begin
      f_pc_d = redirect;
      cnt_d  = '0;
      wr_d   = '0;
      rd_d   = '0;
    end else begin
      if (fire) begin
        f_pc_d       = f_predict_valid ? f_predict_addr : seq_pc;
        tk_d[wr_q]   = f_predict_valid;
        tgt_d[wr_q]  = f_predict_addr;
        ft_d[wr_q]   = seq_pc;
        wr_d         = wr_q + PW'(1);
      end
      if (pop) begin
        rd_d = rd_q + PW'(1);
      end
      cnt_d = cnt_q + CW'(fire) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f_pc_q <= RESET_PC;
      cnt_q  <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      err_q  <= 1'b0;
      tk_q   <= '0;
    end else begin
      f_pc_q <= f_pc_d;
      cnt_q  <= cnt_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      err_q  <= err_d;
      tk_q   <= tk_d;
    end
  end

  // payload is only read under a nonzero count, so it needs no reset
  always_ff @(posedge clk) begin
    tgt_q <= tgt_d;
    ft_q  <= ft_d;
  end

  assign f_pc          = f_pc_q;
  assign f_pc_valid    = pc_valid;
  assign x_mispredict  = mispredict;
  assign x_redirect_pc = redirect;
  assign pq_count      = cnt_q;
  assign x_err         = err_q;

`ifdef FETCH_PC_STATS_EN
  logic [31:0] br_q, br_d;
  logic [31:0] mis_q, mis_d;

  always_comb begin
    br_d  = br_q;
    mis_d = mis_q;
    if (pop & x_is_branch & (br_q != '1)) begin
      br_d = br_q + 32'd1;
    end
    if (mispredict & (mis_q != '1)) begin
      mis_d = mis_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      br_q  <= '0;
      mis_q <= '0;
    end else begin
      br_q  <= br_d;
      mis_q <= mis_d;
    end
  end

  assign stat_branches    = br_q;
  assign stat_mispredicts = mis_q;
`endif

endmodule
